mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of cache-side requesters sharing the C2 memory bus (2..8).
REQ-002 Parameter CMD_WINDOW, default 4, max cycles from grant to requester's first bus command.
REQ-003 Parameter RESP_TIMEOUT, default 255, max cycles from command to memory C2_RESPONSE.
REQ-004 clk  input  1  single clock; all sampling on posedge.
REQ-005 reset  input  1  asynchronous, active-low; reset asserted when low.
REQ-006 req  input  N_REQ  per-requester level request for one C2 bus transaction.
REQ-007 cmd_bus  input  2  snoop of shared C2 cmd lines (C2_* encodings from shared parameter file; undriven/z counts as C2_NOP).
REQ-008 gnt  output  N_REQ  one-hot bus ownership grant, registered.
REQ-009 owner_id  output  $clog2(N_REQ)  index of granted requester, valid while busy.
REQ-010 busy  output  1  high in any state except IDLE.
REQ-011 timeout_err  output  1  one-cycle pulse on response timeout or command-window expiry.

Function
REQ-012 FSM states: IDLE, GRANT, WAIT_RESP, DRAIN, TURN; one transaction per grant.
REQ-013 IDLE: if any req bit high at a posedge, pick winner by round-robin, set gnt[winner]=1, owner_id=winner, go GRANT; otherwise stay.
REQ-014 Round-robin: search starts at (last_winner+1) mod N_REQ; after reset last_winner=N_REQ-1, so index 0 has first priority.
REQ-015 Grant latency: req sampled high at edge k -> gnt visible after edge k (one registered cycle from IDLE).
REQ-016 GRANT: cmd_bus == C2_READ_LINE or C2_WRITE_LINE at a posedge -> go WAIT_RESP, clear window counter.
REQ-017 GRANT: req[owner_id] dropped before a command -> go TURN, no error.
REQ-018 GRANT: CMD_WINDOW posedges elapse without a command -> pulse timeout_err, go TURN.
REQ-019 WAIT_RESP: cycle counter increments each posedge; cmd_bus == C2_RESPONSE -> go DRAIN.
REQ-020 WAIT_RESP: counter reaches RESP_TIMEOUT without C2_RESPONSE -> pulse timeout_err, go TURN.
REQ-021 DRAIN: stay while cmd_bus == C2_RESPONSE (multi-beat read data); first posedge with cmd_bus != C2_RESPONSE -> go TURN.
REQ-022 gnt stays asserted through GRANT, WAIT_RESP and DRAIN; cleared on entry to TURN.
REQ-023 TURN: exactly one cycle, all gnt low (bus float/turnaround), then IDLE; last_winner=owner_id.
REQ-024 A requester holding req after its transaction is re-arbitrated fairly; it is not granted back-to-back while another req bit is high.
REQ-025 gnt never has more than one bit set; gnt never changes except on IDLE->GRANT and entry to TURN.
REQ-026 req changes of non-owners during a transaction are ignored until IDLE.
REQ-027 Counters are saturating, width $clog2(max(CMD_WINDOW,RESP_TIMEOUT)+1); no wrap-around.
REQ-028 timeout_err is low in every cycle not covered by REQ-018/REQ-020.

Reset
REQ-029 reset low forces, asynchronously: state=IDLE, gnt=0, owner_id=0, busy=0, timeout_err=0, counters=0, last_winner=N_REQ-1.
REQ-030 reset low mid-transaction drops gnt immediately; no pulse on timeout_err; after release arbitration restarts from index 0.
REQ-031 First arbitration is possible at the first posedge after reset goes high.

Verification
REQ-032 req=2'b01, cmd READ_LINE 1 cycle after gnt, RESPONSE 8 cycles later held 4 cycles -> gnt=01 from edge after req through last RESPONSE beat, one TURN cycle, busy low after.
REQ-033 req=2'b11 held continuously, each side finishes a WRITE_LINE -> grant order 0,1,0,1 with one all-zero gnt cycle between grants.
REQ-034 gnt=01, no command for CMD_WINDOW=4 cycles -> timeout_err pulse one cycle, gnt=00, returns IDLE.
REQ-035 READ_LINE issued, no RESPONSE for 255 cycles -> timeout_err pulse at cycle 255, gnt=00 next cycle.
REQ-036 reset driven low during DRAIN -> gnt=00, busy=0 without waiting for clk; with req=2'b11 after release, gnt=01 first.
REQ-037 req[0] dropped in GRANT before command -> TURN, no timeout_err, req[1] granted next arbitration.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// C2 command encodings and the arbiter/requester bus bundle.
// Requesters use the master side; the arbiter uses the slave side.
package c2_bus_pkg;
  localparam logic [1:0] C2_NOP        = 2'b00;
  localparam logic [1:0] C2_READ_LINE  = 2'b01;
  localparam logic [1:0] C2_WRITE_LINE = 2'b10;
  localparam logic [1:0] C2_RESPONSE   = 2'b11;
endpackage

interface mem_bus_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [1:0]       cmd_bus;
  logic [N_REQ-1:0] gnt;
  logic [OW-1:0]    owner_id;
  logic             busy;
  logic             timeout_err;

  modport master (
    output req, cmd_bus,
    input  gnt, owner_id, busy, timeout_err
  );

  modport slave (
    input  req, cmd_bus,
    output gnt, owner_id, busy, timeout_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared C2 memory bus: one transaction per
// grant, command-window and response timeouts, one-cycle bus turnaround.
module mem_bus_arbiter
  import c2_bus_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int CMD_WINDOW   = 4,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  localparam int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int T_MAX = (CMD_WINDOW > RESP_TIMEOUT) ? CMD_WINDOW : RESP_TIMEOUT;
  localparam int CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_RESP,
    S_DRAIN,
    S_TURN
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_last;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_err;

  logic [OW-1:0]    w_winner;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_cmd_line;
  logic             w_cmd_resp;
  logic             w_owner_req;

  // An undriven (x/z) cmd_bus fails both compares, so it behaves as C2_NOP.
  assign w_cmd_line  = (bus.cmd_bus == C2_READ_LINE) || (bus.cmd_bus == C2_WRITE_LINE);
  assign w_cmd_resp  = (bus.cmd_bus == C2_RESPONSE);
  assign w_owner_req = bus.req[r_owner];
  assign w_cnt_inc   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Lowest requester above r_last wins; if none, lowest requester at or
  // below r_last (wrap-around). Descending loops leave the lowest index.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_winner unassigned,
    // which would otherwise infer a latch.
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (OW'(i) <= r_last)) w_winner = OW'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (OW'(i) > r_last)) w_winner = OW'(i);
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= OW'(N_REQ - 1);
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_owner <= w_winner;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (w_cmd_line) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_RESP;
          end else if (!w_owner_req) begin
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_state <= S_TURN;
          end else if (r_cnt == CW'(CMD_WINDOW - 1)) begin
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_state <= S_TURN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WAIT_RESP: begin
          if (w_cmd_resp) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else if (r_cnt == CW'(RESP_TIMEOUT - 1)) begin
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b1;
            r_state <= S_TURN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_DRAIN: begin
          if (!w_cmd_resp) begin
            r_gnt   <= '0;
            r_state <= S_TURN;
          end
        end

        S_TURN: begin
          r_last  <= r_owner;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.owner_id    = r_owner;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_err;

endmodule
